// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - opcode and state encodings shared by the HI/LO multiply/divide unit
package muldiv_pkg;

   typedef enum logic [2:0] {
      MULDIV_OP_NONE  = 3'd0,
      MULDIV_OP_MULT  = 3'd1,
      MULDIV_OP_MULTU = 3'd2,
      MULDIV_OP_DIV   = 3'd3,
      MULDIV_OP_DIVU  = 3'd4,
      MULDIV_OP_MTHI  = 3'd5,
      MULDIV_OP_MTLO  = 3'd6
   } muldiv_op_e;

   typedef enum logic [1:0] {
      MULDIV_IDLE  = 2'd0,
      MULDIV_RUN   = 2'd1,
      MULDIV_FIXUP = 2'd2
   } muldiv_state_e;

   function automatic logic is_iter_op(input logic [2:0] op);
      return op inside {MULDIV_OP_MULT, MULDIV_OP_MULTU, MULDIV_OP_DIV, MULDIV_OP_DIVU};
   endfunction

   function automatic logic is_signed_op(input logic [2:0] op);
      return op inside {MULDIV_OP_MULT, MULDIV_OP_DIV};
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return op inside {MULDIV_OP_DIV, MULDIV_OP_DIVU};
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - EX-stage request and HI/LO result bundle for the muldiv unit
interface muldiv_if #(
   parameter int DATA_WIDTH = 32
);
   logic [2:0]            op;
   logic                  start;
   logic                  flush;
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] hi;
   logic [DATA_WIDTH-1:0] lo;

   modport master (
      output op, start, flush, a, b,
      input  busy, done, hi, lo
   );

   modport slave (
      input  op, start, flush, a, b,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - shared accumulator doing one shift-add or restoring-divide step per cycle
module muldiv_core #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic                    step,
   input  logic                    is_div,
   input  logic [DATA_WIDTH-1:0]   op_a,
   input  logic [DATA_WIDTH-1:0]   op_b,
   output logic [2*DATA_WIDTH-1:0] result
);
   localparam int W = DATA_WIDTH;

   // Multiply: acc = {partial product (W+1), multiplier}; divide: acc = {remainder (W+1), quotient}.
   logic [2*W:0] acc;
   logic [2*W:0] acc_next;
   logic [W-1:0] operand;
   logic         div_mode;
   logic [W:0]   mul_sum;
   logic [W:0]   rem_shift;
   logic [W:0]   trial;

   always_comb begin
      mul_sum   = acc[2*W:W] + {1'b0, (acc[0] ? operand : {W{1'b0}})};
      rem_shift = {acc[2*W-1:W], acc[W-1]};
      trial     = rem_shift - {1'b0, operand};
      acc_next  = {1'b0, mul_sum, acc[W-1:1]};
      if (div_mode) begin
         // A borrow out of the trial subtraction means restore and shift in a 0.
         if (trial[W]) begin
            acc_next = {rem_shift, acc[W-2:0], 1'b0};
         end else begin
            acc_next = {trial, acc[W-2:0], 1'b1};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         operand  <= '0;
         div_mode <= 1'b0;
      end else if (load) begin
         acc      <= {{(W+1){1'b0}}, op_a};
         operand  <= op_b;
         div_mode <= is_div;
      end else if (step) begin
         acc      <= acc_next;
      end
   end

   assign result = acc[2*W-1:0];

endmodule

// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative HI/LO multiply/divide unit with FSM, sign fixup and HI/LO registers
module muldiv
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 5
) (
   input  logic     clk,
   input  logic     rst_n,
   muldiv_if.slave  bus
);
   localparam int W = DATA_WIDTH;

   muldiv_state_e       state;
   muldiv_state_e       state_next;
   logic [CNT_WIDTH-1:0] cnt;

   logic                busy;
   logic                done;
   logic                accept;
   logic                core_load;
   logic                core_step;
   logic                write_result;

   logic                sgn;
   logic [W-1:0]        a_mag;
   logic [W-1:0]        b_mag;
   logic [W-1:0]        a_raw;
   logic                neg_res;
   logic                neg_rem;
   logic                div_mode;
   logic                div_zero;

   logic [2*W-1:0]      core_result;
   logic [2*W-1:0]      prod_fix;
   logic [W-1:0]        quo;
   logic [W-1:0]        rem;
   logic [W-1:0]        fix_hi;
   logic [W-1:0]        fix_lo;
   logic [W-1:0]        hi_q;
   logic [W-1:0]        lo_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= MULDIV_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         MULDIV_IDLE: begin
            if (bus.start && !bus.flush && is_iter_op(bus.op)) begin
               state_next = MULDIV_RUN;
            end
         end
         MULDIV_RUN: begin
            if (bus.flush) begin
               state_next = MULDIV_IDLE;
            end else if (cnt == '0) begin
               state_next = MULDIV_FIXUP;
            end
         end
         MULDIV_FIXUP: state_next = MULDIV_IDLE;
         default:      state_next = MULDIV_IDLE;
      endcase
   end

   always_comb begin
      busy         = (state != MULDIV_IDLE);
      accept       = bus.start && !bus.flush && (state == MULDIV_IDLE);
      core_load    = accept && is_iter_op(bus.op);
      core_step    = (state == MULDIV_RUN);
      // A flush landing on FIXUP kills both the write and the done pulse.
      done         = (state == MULDIV_FIXUP) && !bus.flush;
      write_result = done;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (bus.flush) begin
         cnt <= '0;
      end else if (core_load) begin
         cnt <= CNT_WIDTH'(DATA_WIDTH - 1);
      end else if (state == MULDIV_RUN && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   always_comb begin
      sgn   = is_signed_op(bus.op);
      a_mag = (sgn && bus.a[W-1]) ? -bus.a : bus.a;
      b_mag = (sgn && bus.b[W-1]) ? -bus.b : bus.b;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_raw    <= '0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_mode <= 1'b0;
         div_zero <= 1'b0;
      end else if (core_load) begin
         a_raw    <= bus.a;
         neg_res  <= sgn && (bus.a[W-1] ^ bus.b[W-1]);
         neg_rem  <= sgn && bus.a[W-1];
         div_mode <= is_div_op(bus.op);
         div_zero <= is_div_op(bus.op) && (bus.b == '0);
      end
   end

   muldiv_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (core_load),
      .step   (core_step),
      .is_div (is_div_op(bus.op)),
      .op_a   (a_mag),
      .op_b   (b_mag),
      .result (core_result)
   );

   always_comb begin
      prod_fix = neg_res ? -core_result : core_result;
      quo      = core_result[W-1:0];
      rem      = core_result[2*W-1:W];
      if (div_zero) begin
         fix_hi = a_raw;
         fix_lo = '1;
      end else if (div_mode) begin
         fix_hi = neg_rem ? -rem : rem;
         fix_lo = neg_res ? -quo : quo;
      end else begin
         fix_hi = prod_fix[2*W-1:W];
         fix_lo = prod_fix[W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (write_result) begin
         hi_q <= fix_hi;
         lo_q <= fix_lo;
      end else if (accept && bus.op == MULDIV_OP_MTHI) begin
         hi_q <= bus.a;
      end else if (accept && bus.op == MULDIV_OP_MTLO) begin
         lo_q <= bus.a;
      end
   end

   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// tb/tb_muldiv.sv - self-checking bench for muldiv against an arithmetic HI/LO model
module tb_muldiv;
   import muldiv_pkg::*;

   logic clk;
   logic rst_n;

   muldiv_if #(.DATA_WIDTH(32)) bus ();

   muldiv #(
      .DATA_WIDTH (32),
      .CNT_WIDTH  (5)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state: an accepted iterative op becomes visible 34 cycles after its accept edge.
   logic        m_pending = 1'b0;
   int          m_age = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic [63:0] m_res = '0;
   logic        m_new = 1'b0;
   int          n_done = 0;
   int          run_len = 0;

   function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] x,
                                                input logic [31:0] y);
      longint          sx, sy, p;
      longint unsigned ux, uy, up;
      logic [63:0]     r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      r  = '0;
      case (o)
         MULDIV_OP_MULT:  r = sx * sy;
         MULDIV_OP_MULTU: r = ux * uy;
         MULDIV_OP_DIV: begin
            if (y == 32'd0) begin
               r = {x, 32'hFFFF_FFFF};
            end else begin
               p = sx / sy;
               r[31:0] = p[31:0];
               p = sx % sy;
               r[63:32] = p[31:0];
            end
         end
         MULDIV_OP_DIVU: begin
            if (y == 32'd0) begin
               r = {x, 32'hFFFF_FFFF};
            end else begin
               up = ux / uy;
               r[31:0] = up[31:0];
               up = ux % uy;
               r[63:32] = up[31:0];
            end
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   // Hand-computed {hi, lo} for each completed iterative op, in issue order.
   function automatic logic [63:0] lit(input int i);
      case (i)
         0: return 64'hFFFF_FFFE_0000_0001;
         1: return 64'hFFFF_FFFF_FFFF_FFF1;
         2: return 64'h0000_0002_0000_000E;
         3: return 64'hFFFF_FFFF_FFFF_FFFD;
         4: return 64'h0000_0000_8000_0000;
         5: return 64'h0000_0005_FFFF_FFFF;
         6: return 64'hFFFF_FFFB_FFFF_FFFF;
         7: return 64'h0000_0001_2345_6780;
         8: return 64'hC000_0000_8000_0000;
         9: return 64'h0000_0001_FFFF_FFFD;
         default: return 64'h0;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pending = 1'b0;
         m_age     = 0;
         m_hi      = '0;
         m_lo      = '0;
         m_new     = 1'b0;
      end else begin
         m_new = 1'b0;
         if (m_pending) begin
            if (bus.flush) begin
               m_pending = 1'b0;
            end else if (m_age == 33) begin
               m_hi      = m_res[63:32];
               m_lo      = m_res[31:0];
               m_pending = 1'b0;
               m_new     = 1'b1;
               n_done    = n_done + 1;
            end else begin
               m_age = m_age + 1;
            end
         end else if (bus.start && !bus.flush) begin
            if (bus.op == MULDIV_OP_MTHI) begin
               m_hi = bus.a;
            end else if (bus.op == MULDIV_OP_MTLO) begin
               m_lo = bus.a;
            end else if (is_iter_op(bus.op)) begin
               m_res     = model_result(bus.op, bus.a, bus.b);
               m_pending = 1'b1;
               m_age     = 1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic        exp_done;
      logic [63:0] litv;
      exp_done = m_pending && (m_age == 33) && !bus.flush;
      chk("busy", 64'(bus.busy), 64'(m_pending));
      chk("done", 64'(bus.done), 64'(exp_done));
      chk("hi", 64'(bus.hi), 64'(m_hi));
      chk("lo", 64'(bus.lo), 64'(m_lo));
      if (m_new) begin
         litv = lit(n_done - 1);
         chk("lit_hi", 64'(bus.hi), 64'(litv[63:32]));
         chk("lit_lo", 64'(bus.lo), 64'(litv[31:0]));
         chk("model_pin", {m_hi, m_lo}, litv);
         chk("busy_len", 64'(run_len), 64'd33);
      end
      run_len = bus.busy ? run_len + 1 : 0;
   end

   task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic fl);
      @(posedge clk); #1;
      bus.op    = o;
      bus.a     = av;
      bus.b     = bv;
      bus.start = 1'b1;
      bus.flush = fl;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.op    = MULDIV_OP_NONE;
   endtask

   task automatic run_iter(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
      issue(o, av, bv, 1'b0);
      repeat (34) @(posedge clk);
   endtask

   initial begin
      rst_n     = 1'b0;
      bus.op    = MULDIV_OP_NONE;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;

      run_iter(MULDIV_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_iter(MULDIV_OP_MULT,  32'hFFFF_FFFD, 32'd5);
      run_iter(MULDIV_OP_DIVU,  32'd100, 32'd7);
      run_iter(MULDIV_OP_DIV,   32'hFFFF_FFF9, 32'd2);
      run_iter(MULDIV_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
      run_iter(MULDIV_OP_DIVU,  32'd5, 32'd0);
      run_iter(MULDIV_OP_DIV,   32'hFFFF_FFFB, 32'd0);

      issue(MULDIV_OP_MTHI, 32'h11, 32'h0, 1'b0);
      issue(MULDIV_OP_MTLO, 32'h22, 32'h0, 1'b0);
      issue(MULDIV_OP_MULT, 32'd3, 32'd4, 1'b0);
      repeat (9) @(posedge clk);
      #1 bus.flush = 1'b1;
      @(posedge clk); #1 bus.flush = 1'b0;
      repeat (3) @(posedge clk);
      issue(MULDIV_OP_MULT, 32'd3, 32'd4, 1'b1);
      repeat (3) @(posedge clk);
      issue(3'd7, 32'hDEAD_BEEF, 32'h1, 1'b0);
      repeat (2) @(posedge clk);

      issue(MULDIV_OP_DIVU, 32'd1000, 32'd3, 1'b0);
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      issue(MULDIV_OP_MTLO, 32'h0000_ABCD, 32'h0, 1'b0);
      repeat (2) @(posedge clk);

      issue(MULDIV_OP_MULTU, 32'h1234_5678, 32'h10, 1'b0);
      repeat (5) @(posedge clk);
      issue(MULDIV_OP_DIVU, 32'd9, 32'd3, 1'b0);
      repeat (30) @(posedge clk);

      run_iter(MULDIV_OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000);
      run_iter(MULDIV_OP_DIV,  32'd7, 32'hFFFF_FFFE);
      repeat (3) @(posedge clk);

      @(negedge clk);
      checks = checks + 1;
      if (n_done != 10) begin
         errors = errors + 1;
         $display("FAIL completed_ops: got %0d, expected 10", n_done);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
